// File: rtl/trap_pkg.sv
// ---------------------------------------------------------------------------
// trap_pkg
// Shared definitions for the machine-mode trap controller: CSR addresses,
// synchronous exception cause codes, the CSR operation encoding, the
// controller state enum and a helper that legalises mtvec modes.
// No ports; imported by trap_csr_file and trap_unit_vec.
// ---------------------------------------------------------------------------
package trap_pkg;

  // Machine trap CSR addresses
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  // Synchronous exception cause codes
  localparam logic [4:0] CAUSE_ILLEGAL_INST   = 5'd2;
  localparam logic [4:0] CAUSE_L_ACCESS_FAULT = 5'd5;
  localparam logic [4:0] CAUSE_S_ACCESS_FAULT = 5'd7;
  localparam logic [4:0] CAUSE_ECALL_M        = 5'd11;

  // Interrupt line i lives at mip/mie bit IRQ_BASE+i and uses cause IRQ_BASE+i
  localparam int IRQ_BASE = 16;

  // mstatus bit positions that are actually stored
  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;

  // mtvec mode field values
  localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
  localparam logic [1:0] MTVEC_VECTORED = 2'b01;

  typedef enum logic [1:0] {
    CSR_WRITE = 2'b00,
    CSR_SET   = 2'b01,
    CSR_CLEAR = 2'b10,
    CSR_READ  = 2'b11
  } csr_op_e;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_REDIRECT = 1'b1
  } trap_state_e;

  // Reserved mtvec modes (1x) collapse to direct mode when written
  function automatic logic [1:0] legal_mtvec_mode(input logic [1:0] mode);
    return mode[1] ? MTVEC_DIRECT : mode;
  endfunction

endpackage

// File: rtl/trap_csr_file.sv
// ---------------------------------------------------------------------------
// trap_csr_file
// Storage for the machine trap CSRs (mstatus, mie, mip, mtvec, mepc, mcause),
// the combinational read mux and the write/set/clear update logic. Trap entry
// and mret side effects are applied here when the controller requests them.
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   i_irq            raw interrupt lines, sampled into mip every cycle
//   i_trap_take      trap entry this cycle (i_trap_cause / i_trap_epc valid)
//   i_mret_take      mret accepted this cycle
//   i_csr_we         CSR modify accepted this cycle (i_csr_op/addr/wdata)
//   o_rdata          old value of the CSR at i_csr_addr (0 if unimplemented)
//   o_mstatus_mie    mstatus.MIE
//   o_mie, o_mip     interrupt enable / pending registers
//   o_mtvec, o_mepc  trap vector base+mode, exception PC
// ---------------------------------------------------------------------------
module trap_csr_file
  import trap_pkg::*;
#(
  parameter int NUM_IRQ = 4,
  parameter int XLEN    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] i_irq,
  input  logic               i_trap_take,
  input  logic [XLEN-1:0]    i_trap_cause,
  input  logic [XLEN-1:0]    i_trap_epc,
  input  logic               i_mret_take,
  input  logic               i_csr_we,
  input  csr_op_e            i_csr_op,
  input  logic [11:0]        i_csr_addr,
  input  logic [XLEN-1:0]    i_csr_wdata,
  output logic [XLEN-1:0]    o_rdata,
  output logic               o_mstatus_mie,
  output logic [XLEN-1:0]    o_mie,
  output logic [XLEN-1:0]    o_mip,
  output logic [XLEN-1:0]    o_mtvec,
  output logic [XLEN-1:0]    o_mepc
);

  // Only the bits backed by a real interrupt line are writable in mie
  localparam logic [XLEN-1:0] IRQ_MASK =
    XLEN'(((64'd1 << NUM_IRQ) - 64'd1) << IRQ_BASE);

  logic            r_mstatus_mie;
  logic            r_mstatus_mpie;
  logic [XLEN-1:0] r_mie;
  logic [XLEN-1:0] r_mip;
  logic [XLEN-1:0] r_mtvec;
  logic [XLEN-1:0] r_mepc;
  logic [XLEN-1:0] r_mcause;
  logic [XLEN-1:0] w_mstatus;
  logic [XLEN-1:0] w_modified;

  // Assemble the architectural mstatus view; MPP is hardwired to machine mode
  always_comb begin
    w_mstatus                   = '0;
    w_mstatus[12:11]            = 2'b11;
    w_mstatus[MSTATUS_MPIE_BIT] = r_mstatus_mpie;
    w_mstatus[MSTATUS_MIE_BIT]  = r_mstatus_mie;
  end

  // Read mux returns the pre-update value so csrrw/csrrs/csrrc see the old CSR
  always_comb begin
    o_rdata = '0;
    case (i_csr_addr)
      CSR_MSTATUS: o_rdata = w_mstatus;
      CSR_MIE:     o_rdata = r_mie;
      CSR_MTVEC:   o_rdata = r_mtvec;
      CSR_MEPC:    o_rdata = r_mepc;
      CSR_MCAUSE:  o_rdata = r_mcause;
      CSR_MIP:     o_rdata = r_mip;
      default:     o_rdata = '0;
    endcase
  end

  // New CSR value for write / set / clear built from the old value
  always_comb begin
    w_modified = o_rdata;
    case (i_csr_op)
      CSR_WRITE: w_modified = i_csr_wdata;
      CSR_SET:   w_modified = o_rdata | i_csr_wdata;
      CSR_CLEAR: w_modified = o_rdata & ~i_csr_wdata;
      default:   w_modified = o_rdata;
    endcase
  end

  // Register update: trap entry beats mret beats a software CSR write; the
  // controller already guarantees at most one of them is requested, but the
  // ordering keeps the intent explicit. mip just tracks the irq lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie          <= '0;
      r_mip          <= '0;
      r_mtvec        <= '0;
      r_mepc         <= '0;
      r_mcause       <= '0;
    end else begin
      r_mip <= XLEN'(i_irq) << IRQ_BASE;
      if (i_trap_take) begin
        r_mepc         <= i_trap_epc;
        r_mcause       <= i_trap_cause;
        r_mstatus_mpie <= r_mstatus_mie;
        r_mstatus_mie  <= 1'b0;
      end else if (i_mret_take) begin
        r_mstatus_mie  <= r_mstatus_mpie;
        r_mstatus_mpie <= 1'b1;
      end else if (i_csr_we) begin
        case (i_csr_addr)
          CSR_MSTATUS: begin
            r_mstatus_mie  <= w_modified[MSTATUS_MIE_BIT];
            r_mstatus_mpie <= w_modified[MSTATUS_MPIE_BIT];
          end
          CSR_MIE:    r_mie    <= w_modified & IRQ_MASK;
          CSR_MTVEC:  r_mtvec  <= {w_modified[XLEN-1:2],
                                   legal_mtvec_mode(w_modified[1:0])};
          CSR_MEPC:   r_mepc   <= w_modified;
          CSR_MCAUSE: r_mcause <= w_modified;
          default: ;
        endcase
      end
    end
  end

  assign o_mstatus_mie = r_mstatus_mie;
  assign o_mie         = r_mie;
  assign o_mip         = r_mip;
  assign o_mtvec       = r_mtvec;
  assign o_mepc        = r_mepc;

endmodule

// File: rtl/trap_unit_vec.sv
// ---------------------------------------------------------------------------
// trap_unit_vec
// Machine-mode trap controller beside the MEM stage. Arbitrates synchronous
// exceptions, level interrupts, mret and CSR instructions, computes the
// direct/vectored trap target and drives pipeline flushes plus a one-cycle
// PC redirect.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   csr_rw_in, csr_wsc_mode_in    CSR instruction valid and op (wr/set/clr/rd)
//   csr_w_imm_mux                 1 = zero-extended csr_w_data_imm operand
//   csr_rw_addr_in                CSR address
//   csr_w_data_reg/_imm           register / immediate operands
//   csr_r_data_out                old value of the addressed CSR
//   irq                           level interrupt requests
//   illegal_inst, l_access_fault,
//   s_access_fault, ecall_m       exceptions of the MEM instruction
//   mret                          mret in MEM
//   epc_cur, epc_next             PC of MEM instruction / next to commit
//   PC_redirect, redirect_mux     redirect target and select
//   reg_*_flush, RegWrite_cancel  pipeline flushes and writeback suppression
// ---------------------------------------------------------------------------
module trap_unit_vec
  import trap_pkg::*;
#(
  parameter int NUM_IRQ = 4,
  parameter int XLEN    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               csr_rw_in,
  input  logic [1:0]         csr_wsc_mode_in,
  input  logic               csr_w_imm_mux,
  input  logic [11:0]        csr_rw_addr_in,
  input  logic [XLEN-1:0]    csr_w_data_reg,
  input  logic [4:0]         csr_w_data_imm,
  output logic [XLEN-1:0]    csr_r_data_out,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               illegal_inst,
  input  logic               l_access_fault,
  input  logic               s_access_fault,
  input  logic               ecall_m,
  input  logic               mret,
  input  logic [XLEN-1:0]    epc_cur,
  input  logic [XLEN-1:0]    epc_next,
  output logic [XLEN-1:0]    PC_redirect,
  output logic               redirect_mux,
  output logic               reg_FD_flush,
  output logic               reg_DE_flush,
  output logic               reg_EM_flush,
  output logic               reg_MW_flush,
  output logic               RegWrite_cancel
);

  localparam logic [XLEN-1:0] IRQ_MASK =
    XLEN'(((64'd1 << NUM_IRQ) - 64'd1) << IRQ_BASE);

  trap_state_e     r_state;
  trap_state_e     w_state_next;
  logic [XLEN-1:0] r_target;
  logic [XLEN-1:0] w_target_next;

  logic            w_exc;
  logic [4:0]      w_exc_code;
  logic [XLEN-1:0] w_irq_active;
  logic            w_irq_pend;
  logic [4:0]      w_irq_code;
  logic            w_idle;
  logic            w_trap_take;
  logic            w_mret_take;
  logic            w_csr_we;
  logic [XLEN-1:0] w_trap_cause;
  logic [XLEN-1:0] w_trap_epc;
  logic [XLEN-1:0] w_csr_wdata;
  logic [XLEN-1:0] w_vec_base;
  logic [XLEN-1:0] w_vector;

  logic            w_mstatus_mie;
  logic [XLEN-1:0] w_mie;
  logic [XLEN-1:0] w_mip;
  logic [XLEN-1:0] w_mtvec;
  logic [XLEN-1:0] w_mepc;

  // Fixed-priority exception select: illegal > ecall > store fault > load fault
  always_comb begin
    w_exc      = illegal_inst | ecall_m | s_access_fault | l_access_fault;
    w_exc_code = CAUSE_L_ACCESS_FAULT;
    if (illegal_inst)        w_exc_code = CAUSE_ILLEGAL_INST;
    else if (ecall_m)        w_exc_code = CAUSE_ECALL_M;
    else if (s_access_fault) w_exc_code = CAUSE_S_ACCESS_FAULT;
  end

  // Interrupt select: scan from the top down so the lowest active line wins
  always_comb begin
    w_irq_active = w_mie & w_mip & IRQ_MASK;
    w_irq_pend   = w_mstatus_mie && (|w_irq_active);
    w_irq_code   = 5'(IRQ_BASE);
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_irq_active[IRQ_BASE + i]) w_irq_code = 5'(IRQ_BASE + i);
    end
  end

  // Arbitration: exception > interrupt > mret > CSR op, and nothing is
  // accepted outside IDLE or while reset is asserted
  always_comb begin
    w_idle       = (r_state == ST_IDLE) && !rst;
    w_trap_take  = w_idle && (w_exc || w_irq_pend);
    w_mret_take  = w_idle && !(w_exc || w_irq_pend) && mret;
    w_csr_we     = w_idle && !(w_exc || w_irq_pend) && !mret && csr_rw_in &&
                   (csr_op_e'(csr_wsc_mode_in) != CSR_READ);
    w_trap_cause = w_exc ? XLEN'(w_exc_code)
                         : {1'b1, (XLEN-1)'(w_irq_code)};
    w_trap_epc   = w_exc ? epc_cur : epc_next;
    w_csr_wdata  = csr_w_imm_mux ? XLEN'(csr_w_data_imm) : csr_w_data_reg;
  end

  // Trap target: vectored mode only offsets interrupts, exceptions use base
  always_comb begin
    w_vec_base = w_mtvec & ~XLEN'(3);
    w_vector   = w_vec_base;
    if (w_mtvec[1:0] == MTVEC_VECTORED && !w_exc)
      w_vector = w_vec_base + XLEN'({w_trap_cause[4:0], 2'b00});
  end

  trap_csr_file #(
    .NUM_IRQ (NUM_IRQ),
    .XLEN    (XLEN)
  ) u_csr_file (
    .clk           (clk),
    .rst           (rst),
    .i_irq         (irq),
    .i_trap_take   (w_trap_take),
    .i_trap_cause  (w_trap_cause),
    .i_trap_epc    (w_trap_epc),
    .i_mret_take   (w_mret_take),
    .i_csr_we      (w_csr_we),
    .i_csr_op      (csr_op_e'(csr_wsc_mode_in)),
    .i_csr_addr    (csr_rw_addr_in),
    .i_csr_wdata   (w_csr_wdata),
    .o_rdata       (csr_r_data_out),
    .o_mstatus_mie (w_mstatus_mie),
    .o_mie         (w_mie),
    .o_mip         (w_mip),
    .o_mtvec       (w_mtvec),
    .o_mepc        (w_mepc)
  );

  // State and latched redirect target
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_target <= '0;
    end else begin
      r_state  <= w_state_next;
      r_target <= w_target_next;
    end
  end

  // Next state and pipeline controls; reset forces every control low, which
  // also abandons a redirect that was in flight
  always_comb begin
    w_state_next    = ST_IDLE;
    w_target_next   = r_target;
    PC_redirect     = '0;
    redirect_mux    = 1'b0;
    reg_FD_flush    = 1'b0;
    reg_DE_flush    = 1'b0;
    reg_EM_flush    = 1'b0;
    reg_MW_flush    = 1'b0;
    RegWrite_cancel = 1'b0;
    if (!rst) begin
      case (r_state)
        ST_IDLE: begin
          if (w_trap_take) begin
            w_state_next    = ST_REDIRECT;
            w_target_next   = w_vector;
            reg_FD_flush    = 1'b1;
            reg_DE_flush    = 1'b1;
            reg_EM_flush    = 1'b1;
            reg_MW_flush    = w_exc;
            RegWrite_cancel = w_exc;
          end else if (w_mret_take) begin
            w_state_next  = ST_REDIRECT;
            w_target_next = w_mepc;
            reg_FD_flush  = 1'b1;
            reg_DE_flush  = 1'b1;
            reg_EM_flush  = 1'b1;
          end
        end
        ST_REDIRECT: begin
          w_state_next = ST_IDLE;
          redirect_mux = 1'b1;
          PC_redirect  = r_target;
          reg_FD_flush = 1'b1;
          reg_DE_flush = 1'b1;
          reg_EM_flush = 1'b1;
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

endmodule
